rv_exec_ctrl: RTL and testbench
===============================

// Module: rv_exec_ctrl
// PURPOSE
//  Successor to the single-cycle ALU control decode. Decodes {ALUop, funct7, funct3, is_imm} into a
//  full RV32I 4-bit ALU op, and executes RV32M ops in an iterative sequencer.
//  The sequencer applies valid/ready flow control and holds a stall to the pipeline while busy.
//  Sits in the EX stage between the control unit / ID-EX register and the ALU/writeback mux.
// PARAMETERS
//  XLEN      32  datapath width; must be even, >= 8
//  MUL_BITS  1   multiplier bits retired per cycle; power of 2, must divide XLEN
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     instruction fields and operands valid this cycle
//  in_ready     out  1     unit can accept an M op (state IDLE)
//  aluop_i      in   2     ALUop from control: 00 ld/st/imm, 01 branch, 10 R-type, 11 reserved
//  funct7_i     in   7     instr[31:25]
//  funct3_i     in   3     instr[14:12]
//  is_imm_i     in   1     I-type arithmetic (funct7 ignored except SRAI bit 5)
//  rs1_i        in   XLEN  operand A (M ops only)
//  rs2_i        in   XLEN  operand B (M ops only)
//  alu_op_o     out  4     op to ALU: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL,
//                          0110 SUB, 0111 SLT, 1000 SLTU, 1101 SRA, 1100 NOR (not emitted)
//  md_sel_o     out  1     1 = writeback takes md_result_o instead of ALU result
//  md_valid_o   out  1     one-cycle pulse, md_result_o valid
//  md_result_o  out  XLEN  M-op result, held until next md_valid_o
//  stall_o      out  1     freeze IF/ID/EX while M op in flight
// BEHAVIOUR
//  Decode (combinational):
//  - aluop 00 non-imm -> ADD. aluop 01 -> SUB.
//  - aluop 00 is_imm -> funct3 map: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND,
//    001 SLL, 101 SRL/SRA by funct7[5].
//  - aluop 10, funct7=0000000 -> same funct3 map; funct7=0100000 with f3 000 -> SUB, with f3 101 -> SRA.
//  - aluop 10, funct7=0000001 -> M op. alu_op_o = ADD; md_sel_o = 1.
//  - Illegal/11 combinations -> ADD; no error output.
//  M-op handshake:
//  - Accept when in_valid & in_ready & M op; rs1/rs2/funct3 registered at accept.
//  - stall_o = M op presented & !md_valid_o. The stage holds its inputs stable until md_valid_o.
//  - The op presented in the md_valid_o cycle is NOT re-accepted, since the pipeline advances then.
//  FSM:
//  - IDLE -> MUL (f3 0xx) | DIV (f3 1xx) | DONE (special case) on accept.
//  - MUL -> DONE after XLEN/MUL_BITS cycles. DIV -> DONE after XLEN cycles.
//  - DONE -> IDLE; md_valid_o=1 in DONE. in_ready=1 only in IDLE.
//  - Latency accept->md_valid_o: mul XLEN/MUL_BITS+1, div XLEN+1, special 1 cycle.
//  Arithmetic:
//  - MUL/MULH/MULHSU/MULHU: operands converted to magnitudes per signedness (MULHSU: rs1 signed,
//    rs2 unsigned); 2*XLEN unsigned shift-add product; negated if sign differs.
//  - MUL returns low XLEN bits, MULH* return high XLEN bits.
//  - DIV/DIVU/REM/REMU: restoring divide on magnitudes. Quotient sign = xor of operand signs;
//    remainder sign = dividend sign.
//  Special cases (DONE next cycle):
//  - divisor 0: quotient = all ones, remainder = dividend.
//  - signed overflow (rs1=-2^(XLEN-1), rs2=-1): quotient = rs1, remainder = 0.
//  Reset:
//  - rst -> IDLE; in_ready=1 after reset; md_valid_o=0, md_result_o=0, stall_o driven only by decode.
//  - rst mid-op aborts: no md_valid_o, result discarded, next cycle accepts fresh op.
// STRUCTURE
//  - Package rv_alu_pkg: ALU op localparams (4-bit codes above), ALUop codes, funct7 constants,
//    md_state_t enum {IDLE,MUL,DIV,DONE}, md_op_t from funct3.
//  - Sub-module rv_muldiv_iter: FSM + mul/div datapath + special-case detect.
//  - Top rv_exec_ctrl: decode + handshake glue.
// TESTING
//  1 aluop=10 f7=0100000 f3=000 -> alu_op_o=0110; f7=0000000 f3=101 -> 0101; imm f3=101 f7[5]=1 -> 1101.
//  2 MUL rs1=-3 rs2=7: stall_o=1 for 32 cycles, then md_valid_o pulse at cycle 33 with 0xFFFFFFEB.
//    MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//  3 DIV rs1=-7 rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. Both 33-cycle latency.
//  4 DIVU x/0 -> 0xFFFFFFFF and REM x/0 -> x, each 1 cycle.
//    DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, each 1 cycle.
//  5 rst asserted cycle 10 of a DIV -> no md_valid_o; in_ready=1 next cycle; new MUL 2*3 -> 6.
//  6 Back-to-back M ops held by stall: each accepted once; results in order; no duplicate md_valid_o.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: ALU op codes, control field constants and M-op sequencer types
package rv_alu_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_t;
    typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU} md_op_t;
    function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv_exec_ctrl_if.sv
// rv_exec_ctrl_if: EX-stage decode fields, M-op handshake and result bus
interface rv_exec_ctrl_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop_i;
    logic [6:0]      funct7_i;
    logic [2:0]      funct3_i;
    logic            is_imm_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [3:0]      alu_op_o;
    logic            md_sel_o;
    logic            md_valid_o;
    logic [XLEN-1:0] md_result_o;
    logic            stall_o;
    modport master(output in_valid, aluop_i, funct7_i, funct3_i, is_imm_i, rs1_i, rs2_i,
                   input in_ready, alu_op_o, md_sel_o, md_valid_o, md_result_o, stall_o);
    modport slave(input in_valid, aluop_i, funct7_i, funct3_i, is_imm_i, rs1_i, rs2_i,
                  output in_ready, alu_op_o, md_sel_o, md_valid_o, md_result_o, stall_o);
endinterface

// File: rtl/rv_muldiv_iter.sv
// rv_muldiv_iter: iterative RV32M sequencer, shift-add multiply and restoring divide on magnitudes
module rv_muldiv_iter
    import rv_alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  md_op_t          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] result
);
    localparam int MUL_N = XLEN / MUL_BITS;
    localparam int CW    = $clog2(XLEN);
    md_state_t         state, state_n;
    md_op_t            op_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, mcand, add, prod;
    logic [XLEN-1:0]   sh, rem, res_q, fin, ma, mb;
    logic [XLEN:0]     trial;
    logic              a_sgn, b_sgn, neg_q, neg_r, div0, ovf, is_div, special;
    always_comb begin
        is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        a_sgn   = !(op inside {OP_MULHU, OP_DIVU, OP_REMU}) && a[XLEN-1];
        b_sgn   = (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && b[XLEN-1];
        ma      = a_sgn ? -a : a;
        mb      = b_sgn ? -b : b;
        div0    = b == '0;
        ovf     = (op inside {OP_DIV, OP_REM}) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1;
        special = is_div && (div0 || ovf);
    end
    // mcand holds |a| for multiply, |b| (low half) for divide; sh holds multiplier / dividend-quotient
    always_comb begin
        add = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (sh[i]) add = add + (mcand << i);
        trial = {rem, sh[XLEN-1]} - {1'b0, mcand[XLEN-1:0]};
        prod  = neg_q ? -acc : acc;
        fin   = op_q == OP_MUL ? prod[XLEN-1:0]
              : !(op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? prod[2*XLEN-1:XLEN]
              : (op_q inside {OP_DIV, OP_DIVU}) ? (neg_q ? -sh : sh)
              : (neg_r ? -rem : rem);
    end
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb
        state_n = state == IDLE ? (start ? (special ? DONE : is_div ? DIV : MUL) : IDLE)
                : state == MUL  ? (cnt == CW'(MUL_N-1) ? DONE : MUL)
                : state == DIV  ? (cnt == CW'(XLEN-1) ? DONE : DIV)
                : IDLE;
    always_comb begin
        ready  = state == IDLE;
        valid  = state == DONE;
        result = valid ? fin : res_q;
    end
    always_ff @(posedge clk)
        if (rst) res_q <= '0;
        else if (state == DONE) res_q <= fin;
    always_ff @(posedge clk)
        if (start && state == IDLE) begin
            op_q  <= op;
            cnt   <= '0;
            acc   <= '0;
            mcand <= {{XLEN{1'b0}}, is_div ? mb : ma};
            sh    <= special ? (div0 ? '1 : a) : is_div ? ma : mb;
            rem   <= special && div0 ? a : '0;
            neg_q <= !special && (a_sgn ^ b_sgn);
            neg_r <= !special && a_sgn;
        end else if (state == MUL) begin
            acc   <= acc + add;
            mcand <= mcand << MUL_BITS;
            sh    <= sh >> MUL_BITS;
            cnt   <= cnt + 1'b1;
        end else if (state == DIV) begin
            rem <= trial[XLEN] ? {rem[XLEN-2:0], sh[XLEN-1]} : trial[XLEN-1:0];
            sh  <= {sh[XLEN-2:0], !trial[XLEN]};
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/rv_exec_ctrl.sv
// rv_exec_ctrl: EX-stage ALU op decode plus M-op handshake around the iterative mul/div unit
module rv_exec_ctrl
    import rv_alu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 1
) (
    input logic          clk,
    input logic          rst,
    rv_exec_ctrl_if.slave bus
);
    logic is_m, start;
    always_comb begin
        is_m = bus.aluop_i == ALUOP_R && bus.funct7_i == F7_MULDIV;
        bus.alu_op_o = bus.aluop_i == ALUOP_MEM ? (bus.is_imm_i ? f3_alu(bus.funct3_i, bus.funct7_i[5]) : ALU_ADD)
                     : bus.aluop_i == ALUOP_BR  ? ALU_SUB
                     : bus.aluop_i != ALUOP_R   ? ALU_ADD
                     : bus.funct7_i == F7_BASE  ? f3_alu(bus.funct3_i, 1'b0)
                     : bus.funct7_i != F7_ALT   ? ALU_ADD
                     : bus.funct3_i == 3'b000   ? ALU_SUB
                     : bus.funct3_i == 3'b101   ? ALU_SRA
                     : ALU_ADD;
        bus.md_sel_o = is_m;
        start        = bus.in_valid && is_m && bus.in_ready;
        // the op shown alongside md_valid_o is the finished one, so the pipeline is released then
        bus.stall_o  = bus.in_valid && is_m && !bus.md_valid_o;
    end
    rv_muldiv_iter #(.XLEN(XLEN), .MUL_BITS(MUL_BITS)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (md_op_t'(bus.funct3_i)),
        .a      (bus.rs1_i),
        .b      (bus.rs2_i),
        .ready  (bus.in_ready),
        .valid  (bus.md_valid_o),
        .result (bus.md_result_o)
    );
endmodule

// File: tb/tb_rv_exec_ctrl.sv
// tb_rv_exec_ctrl: directed decode vectors and M-op sequences with hand-computed results
module tb_rv_exec_ctrl;
    typedef struct {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       imm;
        logic [3:0] op;
        logic       sel;
    } dec_t;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0, failures = 0, pulses = 0, exp_pulses = 0;
    dec_t dv [16];
    always #5 clk = ~clk;
    rv_exec_ctrl_if #(.XLEN(32)) bus();
    rv_exec_ctrl #(.XLEN(32), .MUL_BITS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always @(negedge clk)
        if (bus.md_valid_o === 1'b1) pulses++;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask
    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.aluop_i  = 2'b10;
        bus.funct7_i = 7'b0000001;
        bus.funct3_i = f3;
        bus.is_imm_i = 1'b0;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
    endtask
    task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp);
        int lat = 0;
        int bad = 0;
        @(negedge clk);
        present(f3, a, b);
        #1;
        if (bus.stall_o !== ~bus.md_valid_o) bad++;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.stall_o !== ~bus.md_valid_o) bad++;
            if (bus.md_valid_o === 1'b1) break;
        end
        exp_pulses++;
        check({tag, ".res"}, bus.md_result_o, exp);
        check({tag, ".lat"}, lat, lat_exp);
        check({tag, ".stall"}, bad, 0);
    endtask
    initial begin
        dv[0]  = '{2'b10, 7'b0100000, 3'b000, 1'b0, 4'b0110, 1'b0};
        dv[1]  = '{2'b10, 7'b0000000, 3'b101, 1'b0, 4'b0101, 1'b0};
        dv[2]  = '{2'b00, 7'b0100000, 3'b101, 1'b1, 4'b1101, 1'b0};
        dv[3]  = '{2'b00, 7'b0000000, 3'b101, 1'b1, 4'b0101, 1'b0};
        dv[4]  = '{2'b00, 7'b0100000, 3'b111, 1'b0, 4'b0010, 1'b0};
        dv[5]  = '{2'b01, 7'b0000000, 3'b000, 1'b0, 4'b0110, 1'b0};
        dv[6]  = '{2'b00, 7'b0000000, 3'b010, 1'b1, 4'b0111, 1'b0};
        dv[7]  = '{2'b00, 7'b0000000, 3'b011, 1'b1, 4'b1000, 1'b0};
        dv[8]  = '{2'b00, 7'b0000000, 3'b100, 1'b1, 4'b0011, 1'b0};
        dv[9]  = '{2'b00, 7'b0000000, 3'b110, 1'b1, 4'b0001, 1'b0};
        dv[10] = '{2'b00, 7'b0000000, 3'b111, 1'b1, 4'b0000, 1'b0};
        dv[11] = '{2'b10, 7'b0000000, 3'b001, 1'b0, 4'b0100, 1'b0};
        dv[12] = '{2'b10, 7'b0000001, 3'b100, 1'b0, 4'b0010, 1'b1};
        dv[13] = '{2'b11, 7'b0000000, 3'b111, 1'b0, 4'b0010, 1'b0};
        dv[14] = '{2'b10, 7'b0100000, 3'b111, 1'b0, 4'b0010, 1'b0};
        dv[15] = '{2'b10, 7'b0100000, 3'b101, 1'b0, 4'b1101, 1'b0};
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.aluop_i  = 2'b00;
        bus.funct7_i = 7'b0;
        bus.funct3_i = 3'b0;
        bus.is_imm_i = 1'b0;
        bus.rs1_i    = 32'h0;
        bus.rs2_i    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.ready", bus.in_ready, 1);
        check("rst.valid", bus.md_valid_o, 0);
        check("rst.result", bus.md_result_o, 0);
        check("rst.stall", bus.stall_o, 0);
        foreach (dv[i]) begin
            bus.aluop_i  = dv[i].aluop;
            bus.funct7_i = dv[i].f7;
            bus.funct3_i = dv[i].f3;
            bus.is_imm_i = dv[i].imm;
            #1;
            check($sformatf("dec%0d.op", i), bus.alu_op_o, dv[i].op);
            check($sformatf("dec%0d.sel", i), bus.md_sel_o, dv[i].sel);
            check($sformatf("dec%0d.stall", i), bus.stall_o, 0);
        end
        run_m("mul", 3'b000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 33);             idle();
        run_m("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);    idle();
        run_m("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);     idle();
        run_m("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);   idle();
        run_m("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);             idle();
        run_m("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);             idle();
        run_m("div_neg_b", 3'b100, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);       idle();
        run_m("rem_neg_b", 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 33);              idle();
        run_m("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);                       idle();
        run_m("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);                        idle();
        run_m("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 1);                   idle();
        run_m("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 1);                           idle();
        run_m("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);   idle();
        run_m("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);          idle();
        @(negedge clk);
        present(3'b100, 32'hFFFFFFF9, 32'd2);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort.ready", bus.in_ready, 1);
        check("abort.valid", bus.md_valid_o, 0);
        check("abort.result", bus.md_result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        run_m("post_rst_mul", 3'b000, 32'd2, 32'd3, 32'd6, 33);
        run_m("b2b_mul", 3'b000, 32'd5, 32'd6, 32'd30, 34);
        run_m("b2b_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run_m("b2b_rem0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
        idle();
        @(posedge clk);
        #1;
        check("b2b.nodup", bus.md_valid_o, 0);
        check("b2b.held", bus.md_result_o, 32'd5);
        check("b2b.ready", bus.in_ready, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pulses", pulses, exp_pulses);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
